// File: rtl/ssd_pkg.sv
// Shared definitions for the four-digit seven-segment scan path (encoder and capture side).
// Latency: n/a (constants, types and a pure combinational helper function).
// Backpressure: n/a.
//
// Contents: active-low abcdefg encodings for hex digits 0..F, blank constants,
// the capture FSM state type and a table-driven decode helper returning {valid, code}.
package ssd_pkg;

    // Active-low {a,b,c,d,e,f,g}; 0 = segment lit.
    localparam logic [6:0] SEG_0 = 7'b0000001;
    localparam logic [6:0] SEG_1 = 7'b1001111;
    localparam logic [6:0] SEG_2 = 7'b0010010;
    localparam logic [6:0] SEG_3 = 7'b0000110;
    localparam logic [6:0] SEG_4 = 7'b1001100;
    localparam logic [6:0] SEG_5 = 7'b0100100;
    localparam logic [6:0] SEG_6 = 7'b0100000;
    localparam logic [6:0] SEG_7 = 7'b0001111;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0000100;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b1100000;
    localparam logic [6:0] SEG_C = 7'b0110001;
    localparam logic [6:0] SEG_D = 7'b1000010;
    localparam logic [6:0] SEG_E = 7'b0110000;
    localparam logic [6:0] SEG_F = 7'b0111000;

    // Element [i] is the encoding of hex value i.
    localparam logic [15:0][6:0] SEG_TABLE = {
        SEG_F, SEG_E, SEG_D, SEG_C, SEG_B, SEG_A, SEG_9, SEG_8,
        SEG_7, SEG_6, SEG_5, SEG_4, SEG_3, SEG_2, SEG_1, SEG_0
    };

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [3:0] AN_BLANK  = 4'b1111;

    typedef enum logic [1:0] {
        ST_WAIT  = 2'd0,
        ST_COUNT = 2'd1,
        ST_HELD  = 2'd2
    } scan_state_t;

    // Returns {valid, code}; valid = 0 and code = 0 for any pattern outside the table.
    function automatic logic [4:0] seg_decode(input logic [6:0] seg);
        logic [4:0] res;
        res = 5'b0;
        for (int i = 0; i < 16; i++) begin
            if (seg == SEG_TABLE[i]) begin
                res = {1'b1, 4'(i)};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/ssd_seg_decode.sv
// Combinational seven-segment to hex lookup built on the shared encoding table.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows input.
//
// Ports: segments (active-low abcdefg) in; valid (pattern is in table) and code (hex value) out.
module ssd_seg_decode
    import ssd_pkg::*;
(
    input  logic [6:0] segments,
    output logic       valid,
    output logic [3:0] code
);

    always_comb begin
        {valid, code} = seg_decode(segments);
    end

endmodule

// File: rtl/ssd_scan_capture.sv
// Recovers the four hex digits shown on a multiplexed active-low seven-segment display.
// Latency: digit registers update STABLE_CYCLES-1 edges after the first edge that samples a steady pattern.
// Backpressure: none; passive observer, every cycle is sampled and flags are 1-cycle pulses.
//
// Ports: clock, reset (sync, active-high); anode[3:0], segments[6:0] observed lines (active-low);
// digits[15:0], digit_valid[3:0], frame_done, frame_count[7:0], anode_err, seg_err, timeout.
// Optional macro SSD_DP_CAPTURE_EN adds dp (active-low in) and dp_out[3:0] (captured decimal points).
module ssd_scan_capture
    import ssd_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned FRAME_TIMEOUT = 1024
)
(
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  anode,
    input  logic [6:0]  segments,
    output logic [15:0] digits,
    output logic [3:0]  digit_valid,
    output logic        frame_done,
    output logic [7:0]  frame_count,
    output logic        anode_err,
    output logic        seg_err,
    output logic        timeout
`ifdef SSD_DP_CAPTURE_EN
    ,
    input  logic        dp,
    output logic [3:0]  dp_out
`endif
);

`ifdef SSD_DP_CAPTURE_EN
    localparam int SMP_W = 12;
    logic [SMP_W-1:0] cur_smp;
    assign cur_smp = {anode, segments, dp};
`else
    localparam int SMP_W = 11;
    logic [SMP_W-1:0] cur_smp;
    assign cur_smp = {anode, segments};
`endif

    localparam logic [7:0]  STABLE_LAST = 8'(STABLE_CYCLES);
    localparam logic [15:0] TO_LAST     = 16'(FRAME_TIMEOUT - 1);

    scan_state_t      state;
    scan_state_t      state_nx;
    logic [7:0]       cnt;
    logic [7:0]       cnt_nx;
    logic             counting;
    logic             capture;
    logic [SMP_W-1:0] prev_smp;
    logic             same;
    logic             is_single;
    logic             is_illegal;
    logic [1:0]       dig_idx;
    logic [3:0]       dig_sel;
    logic [3:0]       seen;
    logic [3:0]       seen_upd;
    logic [15:0]      tcnt;
    logic             dec_valid;
    logic [3:0]       dec_code;

    ssd_seg_decode u_dec (
        .segments (segments),
        .valid    (dec_valid),
        .code     (dec_code)
    );

    // Input classification: blank, exactly one digit enabled, or illegal.
    always_comb begin
        is_single = 1'b1;
        dig_idx   = 2'd0;
        case (anode)
            4'b1110: dig_idx = 2'd0;
            4'b1101: dig_idx = 2'd1;
            4'b1011: dig_idx = 2'd2;
            4'b0111: dig_idx = 2'd3;
            default: is_single = 1'b0;
        endcase
    end

    assign is_illegal = !is_single && (anode != AN_BLANK);
    assign same       = (cur_smp == prev_smp);
    assign dig_sel    = 4'b0001 << dig_idx;
    assign seen_upd   = seen | dig_sel;

    // Dwell tracking. A pattern that differs from the previous sample always
    // restarts at count 1, so a single pattern is captured once per dwell.
    always_comb begin
        state_nx = ST_WAIT;
        cnt_nx   = '0;
        counting = 1'b0;
        if (is_single) begin
            if (state != ST_WAIT && same) begin
                if (state == ST_HELD) begin
                    state_nx = ST_HELD;
                    cnt_nx   = cnt;
                end else begin
                    state_nx = ST_COUNT;
                    cnt_nx   = cnt + 8'd1;
                    counting = 1'b1;
                end
            end else begin
                state_nx = ST_COUNT;
                cnt_nx   = 8'd1;
                counting = 1'b1;
            end
        end
        capture = counting && (cnt_nx == STABLE_LAST);
        if (capture) begin
            state_nx = ST_HELD;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_WAIT;
            cnt         <= '0;
            prev_smp    <= '0;
            seen        <= '0;
            tcnt        <= '0;
            digits      <= '0;
            digit_valid <= '0;
            frame_done  <= 1'b0;
            frame_count <= '0;
            anode_err   <= 1'b0;
            seg_err     <= 1'b0;
            timeout     <= 1'b0;
`ifdef SSD_DP_CAPTURE_EN
            dp_out      <= '0;
`endif
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            prev_smp   <= cur_smp;
            anode_err  <= is_illegal;
            seg_err    <= capture && !dec_valid;
            frame_done <= 1'b0;
            timeout    <= 1'b0;

            if (capture) begin
                tcnt <= '0;
                if (dec_valid) begin
                    digits[{dig_idx, 2'b00} +: 4] <= dec_code;
                end
                digit_valid[dig_idx] <= dec_valid;
`ifdef SSD_DP_CAPTURE_EN
                dp_out[dig_idx] <= ~dp;
`endif
                // The digit captured this cycle counts toward the frame it completes.
                if (seen_upd == 4'b1111) begin
                    frame_done  <= 1'b1;
                    frame_count <= frame_count + 8'd1;
                    seen        <= '0;
                end else begin
                    seen <= seen_upd;
                end
            end else if (tcnt == TO_LAST) begin
                // Display went quiet: stop vouching for stale digits, keep their values.
                timeout     <= 1'b1;
                tcnt        <= '0;
                digit_valid <= '0;
                seen        <= '0;
            end else begin
                tcnt <= tcnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_ssd_scan_capture.sv
module tb_ssd_scan_capture;

    localparam int STABLE = 4;
    localparam int FTO    = 100;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  anode = 4'b1111;
    logic [6:0]  segments = 7'b1111111;

    logic [15:0] digits;
    logic [3:0]  digit_valid;
    logic        frame_done;
    logic [7:0]  frame_count;
    logic        anode_err;
    logic        seg_err;
    logic        timeout;

    logic [15:0] digits1;
    logic [3:0]  digit_valid1;
    logic        frame_done1;
    logic [7:0]  frame_count1;
    logic        anode_err1;
    logic        seg_err1;
    logic        timeout1;

    always #5 clock = ~clock;

    ssd_scan_capture #(.STABLE_CYCLES(STABLE), .FRAME_TIMEOUT(FTO)) dut (
        .clock       (clock),
        .reset       (reset),
        .anode       (anode),
        .segments    (segments),
        .digits      (digits),
        .digit_valid (digit_valid),
        .frame_done  (frame_done),
        .frame_count (frame_count),
        .anode_err   (anode_err),
        .seg_err     (seg_err),
        .timeout     (timeout)
    );

    // Second instance for the single-sample capture boundary.
    ssd_scan_capture #(.STABLE_CYCLES(1), .FRAME_TIMEOUT(1000)) dut1 (
        .clock       (clock),
        .reset       (reset),
        .anode       (anode),
        .segments    (segments),
        .digits      (digits1),
        .digit_valid (digit_valid1),
        .frame_done  (frame_done1),
        .frame_count (frame_count1),
        .anode_err   (anode_err1),
        .seg_err     (seg_err1),
        .timeout     (timeout1)
    );

    // Independent copy of the display encoding (active-low abcdefg).
    logic [6:0] seg_tab [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];

    int n_chk  = 0;
    int n_pass = 0;
    int n_frame = 0;
    int n_aerr  = 0;
    int n_serr  = 0;
    int n_tout  = 0;
    int b_frame, b_aerr, b_serr, b_tout;

    // Pulse counters, sampled mid-cycle.
    always @(negedge clock) begin
        if (!reset) begin
            n_frame <= n_frame + int'(frame_done);
            n_aerr  <= n_aerr  + int'(anode_err);
            n_serr  <= n_serr  + int'(seg_err);
            n_tout  <= n_tout  + int'(timeout);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic sb_pop(input logic [31:0] obs);
        exp_t e;
        if (sb.size() == 0) begin
            check("sb_underflow", obs, ~obs);
        end else begin
            e = sb.pop_front();
            check(e.tag, obs, e.val);
        end
    endtask

    task automatic cyc(input logic [3:0] an, input logic [6:0] sg);
        @(negedge clock);
        anode    = an;
        segments = sg;
        @(posedge clock);
        #1;
    endtask

    task automatic hold(input logic [3:0] an, input logic [6:0] sg, input int n);
        for (int i = 0; i < n; i++) begin
            cyc(an, sg);
        end
    endtask

    task automatic settle();
        @(negedge clock);
        #1;
    endtask

    task automatic snap();
        b_frame = n_frame;
        b_aerr  = n_aerr;
        b_serr  = n_serr;
        b_tout  = n_tout;
    endtask

    task automatic check_all_zero(input string pfx);
        sb_push({pfx, "_digits"}, 32'h0);
        sb_push({pfx, "_valid"}, 32'h0);
        sb_push({pfx, "_fcount"}, 32'h0);
        sb_push({pfx, "_flags"}, 32'h0);
        sb_pop(32'(digits));
        sb_pop(32'(digit_valid));
        sb_pop(32'(frame_count));
        sb_pop({28'h0, frame_done, anode_err, seg_err, timeout});
    endtask

    logic [3:0] t2_codes [4] = '{4'h3, 4'hA, 4'hB, 4'hF};

    initial begin
        // Reset state
        repeat (3) @(posedge clock);
        #1;
        check_all_zero("reset");
        @(negedge clock);
        reset = 1'b0;
        hold(4'b1111, 7'b1111111, 2);

        // Digit 0 shows '2': capture on the 4th sampling edge, not before.
        snap();
        sb_push("t1_early0", 32'h0);
        sb_push("sc1_valid", 32'h1);
        sb_push("sc1_digits", 32'h2);
        sb_push("sc1_flags", 32'h0);
        cyc(4'b1110, seg_tab[2]);
        sb_pop(32'(digit_valid));
        sb_pop(32'(digit_valid1));
        sb_pop(32'(digits1));
        sb_pop({20'h0, frame_count1, frame_done1, anode_err1, seg_err1, timeout1});
        sb_push("t1_early1", 32'h0);
        cyc(4'b1110, seg_tab[2]);
        sb_pop(32'(digit_valid));
        sb_push("t1_early2", 32'h0);
        cyc(4'b1110, seg_tab[2]);
        sb_pop(32'(digit_valid));
        sb_push("t1_valid", 32'h1);
        sb_push("t1_digits", 32'h2);
        cyc(4'b1110, seg_tab[2]);
        sb_pop(32'(digit_valid));
        sb_pop(32'(digits));
        hold(4'b1110, seg_tab[2], 2);
        hold(4'b1111, 7'b1111111, 1);
        settle();
        sb_push("t1_no_frame", 32'(b_frame));
        sb_push("t1_no_segerr", 32'(b_serr));
        sb_pop(32'(n_frame));
        sb_pop(32'(n_serr));

        // Full scan 3,A,b,F completes exactly one frame.
        snap();
        sb_push("t2_digits", 32'hFBA3);
        sb_push("t2_valid", 32'hF);
        sb_push("t2_fcount", 32'h1);
        sb_push("t2_frames", 32'(b_frame + 1));
        for (int d = 0; d < 4; d++) begin
            hold(~(4'b0001 << d), seg_tab[t2_codes[d]], 16);
            hold(4'b1111, 7'b1111111, 1);
        end
        settle();
        sb_pop(32'(digits));
        sb_pop(32'(digit_valid));
        sb_pop(32'(frame_count));
        sb_pop(32'(n_frame));

        // Illegal anode mid-dwell: two error pulses, dwell restarts from WAIT.
        snap();
        sb_push("t3_aerr", 32'(b_aerr + 2));
        sb_push("t3_digits", 32'hFBA3);
        sb_push("t3_valid", 32'hF);
        hold(4'b1011, seg_tab[5], 2);
        hold(4'b0011, seg_tab[5], 2);
        hold(4'b1011, seg_tab[5], 3);
        hold(4'b1111, 7'b1111111, 1);
        settle();
        sb_pop(32'(n_aerr));
        sb_pop(32'(digits));
        sb_pop(32'(digit_valid));

        // Undecodable pattern on digit 1, held long: one seg_err, no recapture.
        snap();
        sb_push("t4_segerr", 32'(b_serr + 1));
        sb_push("t4_valid", 32'hD);
        sb_push("t4_digits", 32'hFBA3);
        hold(4'b1101, 7'b1111110, 10);
        hold(4'b1111, 7'b1111111, 1);
        settle();
        sb_pop(32'(n_serr));
        sb_pop(32'(digit_valid));
        sb_pop(32'(digits));

        // Segments change every 3 cycles: never stable, so a single timeout fires.
        snap();
        sb_push("t5_timeout", 32'(b_tout + 1));
        sb_push("t5_valid", 32'h0);
        sb_push("t5_digits", 32'hFBA3);
        sb_push("t5_segerr", 32'(b_serr));
        sb_push("t5_frames", 32'(b_frame));
        for (int k = 0; k < 40; k++) begin
            hold(4'b1110, seg_tab[k % 16], 3);
        end
        hold(4'b1111, 7'b1111111, 1);
        settle();
        sb_pop(32'(n_tout));
        sb_pop(32'(digit_valid));
        sb_pop(32'(digits));
        sb_pop(32'(n_serr));
        sb_pop(32'(n_frame));

        // Reset at count 3 abandons the dwell.
        hold(4'b1011, seg_tab[7], 3);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check_all_zero("t6_reset");
        @(negedge clock);
        reset    = 1'b0;
        anode    = 4'b1111;
        segments = 7'b1111111;
        hold(4'b1111, 7'b1111111, 5);
        sb_push("t6_digits", 32'h0);
        sb_push("t6_valid", 32'h0);
        sb_pop(32'(digits));
        sb_pop(32'(digit_valid));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
